// File: rtl/alu_seq_md_if.sv
// Bus between the EX-stage ALU and its neighbours.
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready
// are both high; a result transfers on a rising edge where out_valid &
// out_ready are both high. A producer holding valid high keeps its payload
// stable until the transfer. in_ready may depend on out_ready and flush in
// the same cycle. in_valid, op, a and b never depend on in_ready.
interface alu_seq_md_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;
    logic            zero;
    logic            neg;
    logic            carry;
    logic            ovf;
    logic            illegal;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, res, zero, neg, carry, ovf, illegal
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, res, zero, neg, carry, ovf, illegal
    );
endinterface

// File: rtl/alu_seq_md.sv
// RV32I/M ALU for the EX stage. Single-cycle ops and divide corner cases
// finish in one cycle; multiply and divide iterate one bit per cycle, then
// spend one FIX cycle applying signs. Every result is registered.
module alu_seq_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_md_if.slave bus,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;

    localparam logic [XLEN-1:0] LOW12    = XLEN'(4095);
    localparam logic [XLEN-1:0] UMASK    = ~LOW12;
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN-1);

    state_e          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0] opnd_q, opnd_d; // multiplicand or divisor magnitude
    logic [2:0]      kind_q, kind_d; // op[2:0] of the iterative op
    logic            negr_q, negr_d; // negate result in FIX
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic            ill_q, ill_d;

    logic            in_ready;
    logic            accept;

    // Single-cycle datapath
    logic [XLEN:0]   add_w, sub_w;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_res;
    logic            sc_carry, sc_ovf, sc_ill;

    // Iterative-op setup
    logic [2:0]      md_sel;
    logic            is_iter, is_div, a_sgn, b_sgn, b_zero, div_ovf, special, res_neg;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    // Iteration step and sign fix
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_t;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   fix_res;

    // Result load request shared by the DONE-entering paths
    logic            ld_en, ld_carry, ld_ovf, ld_ill;
    logic [XLEN-1:0] ld_res;

    assign in_ready      = ~bus.flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready));
    assign accept        = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.res       = res_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = ill_q;
    assign state_o       = state_q;

    // Single-cycle result for the op presented on the bus
    always_comb begin
        add_w    = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{XLEN{1'b0}}, 1'b1};
        shamt    = bus.b[SHW-1:0];
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (bus.op)
            5'h00: begin
                sc_res   = add_w[XLEN-1:0];
                sc_carry = add_w[XLEN];
                sc_ovf   = (bus.a[XLEN-1] == bus.b[XLEN-1]) && (add_w[XLEN-1] != bus.a[XLEN-1]);
            end
            5'h01: begin
                sc_res   = sub_w[XLEN-1:0];
                sc_carry = sub_w[XLEN];
                sc_ovf   = (bus.a[XLEN-1] != bus.b[XLEN-1]) && (sub_w[XLEN-1] != bus.a[XLEN-1]);
            end
            5'h02: sc_res = bus.a & bus.b;
            5'h03: sc_res = bus.a | bus.b;
            5'h04: sc_res = bus.a ^ bus.b;
            5'h05: sc_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            5'h06: sc_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            5'h07: sc_res = bus.a & UMASK;
            5'h08: sc_res = bus.a + (bus.b & UMASK);
            5'h09: sc_res = bus.b & UMASK;
            5'h0A: sc_res = bus.a << shamt;
            5'h0B: sc_res = $unsigned($signed(bus.a) >>> shamt);
            5'h0C: sc_res = bus.a >> shamt;
            default: sc_ill = 1'b1;
        endcase
    end

    // Operand magnitudes, result sign and divide corner cases
    always_comb begin
        md_sel   = bus.op[2:0];
        is_iter  = (bus.op[4:3] == 2'b10);
        is_div   = md_sel[2];
        a_sgn    = ((md_sel == 3'd1) || (md_sel == 3'd2) || (md_sel == 3'd4) || (md_sel == 3'd6))
                   && bus.a[XLEN-1];
        b_sgn    = ((md_sel == 3'd1) || (md_sel == 3'd4) || (md_sel == 3'd6)) && bus.b[XLEN-1];
        mag_a    = a_sgn ? -bus.a : bus.a;
        mag_b    = b_sgn ? -bus.b : bus.b;
        b_zero   = (bus.b == '0);
        div_ovf  = ~md_sel[0] && (bus.a == MIN_VAL) && (bus.b == '1);
        special  = is_div && (b_zero || div_ovf);
        // REM/REMU take the dividend's sign, everything else the xor
        res_neg  = (is_div && md_sel[1]) ? a_sgn : (a_sgn ^ b_sgn);
        if (b_zero) begin
            spec_res = md_sel[1] ? bus.a : '1;
        end else begin
            spec_res = md_sel[1] ? '0 : MIN_VAL;
        end
    end

    // One shift-add or restoring-divide step, plus the FIX-cycle sign handling
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_t    = {acc_q, lo_q[XLEN-1]};
        div_ge   = (div_t >= {1'b0, opnd_q});
        div_diff = div_t[XLEN-1:0] - opnd_q;
        prod     = {acc_q, lo_q};
        prod_fix = negr_q ? -prod : prod;
        case (kind_q)
            3'd0:          fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fix_res = negr_q ? -lo_q : lo_q;
            default:       fix_res = negr_q ? -acc_q : acc_q;
        endcase
    end

    // Next state, iteration registers and result registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        kind_d   = kind_q;
        negr_d   = negr_q;
        res_d    = res_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        ld_en    = 1'b0;
        ld_res   = '0;
        ld_carry = 1'b0;
        ld_ovf   = 1'b0;
        ld_ill   = 1'b0;

        case (state_q)
            S_BUSY: begin
                if (kind_q[2]) begin
                    acc_d = div_ge ? div_diff : div_t[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[XLEN:1];
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            S_FIX: begin
                ld_en   = 1'b1;
                ld_res  = fix_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (is_iter && !special) begin
                acc_d   = '0;
                lo_d    = mag_a;
                opnd_d  = mag_b;
                kind_d  = md_sel;
                negr_d  = res_neg;
                cnt_d   = '0;
                state_d = S_BUSY;
            end else begin
                state_d = S_DONE;
                ld_en   = 1'b1;
                if (is_iter) begin
                    ld_res = spec_res;
                end else if (sc_ill) begin
                    ld_ill = 1'b1;
                end else begin
                    ld_res   = sc_res;
                    ld_carry = sc_carry;
                    ld_ovf   = sc_ovf;
                end
            end
        end

        // Abort wins over everything, including a result about to land
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ld_en   = 1'b0;
        end

        if (ld_en) begin
            res_d   = ld_res;
            zero_d  = (ld_res == '0);
            neg_d   = ld_res[XLEN-1];
            carry_d = ld_carry;
            ovf_d   = ld_ovf;
            ill_d   = ld_ill;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            kind_q  <= '0;
            negr_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            kind_q  <= kind_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_md.sv
// Bench for alu_seq_md: directed cases with literal results, then random
// traffic checked every cycle against an arithmetic reference model.
module tb_alu_seq_md;
    localparam int XLEN = 32;
    localparam int W    = 35; // {illegal, carry, ovf, res}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_md_if #(.XLEN(XLEN)) bus();
    logic [1:0] dbg_state;

    alu_seq_md #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [4:0] last_flags; // {zero, neg, carry, ovf, illegal}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        c, v, il;
        longint      sa, sb, ua, ub, p;
        logic [63:0] pb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
        case (op)
            5'd0: begin
                p = ua + ub; pb = p; r = pb[31:0]; c = pb[32];
                v = ((sa + sb) != longint'($signed(r)));
            end
            5'd1: begin
                r = a - b; c = (a >= b);
                v = ((sa - sb) != longint'($signed(r)));
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd6: r = (a < b) ? 32'd1 : 32'd0;
            5'd7: r = a & 32'hFFFFF000;
            5'd8: r = a + (b & 32'hFFFFF000);
            5'd9: r = b & 32'hFFFFF000;
            5'd10: r = a << b[4:0];
            5'd11: begin p = sa >>> b[4:0]; pb = p; r = pb[31:0]; end
            5'd12: r = a >> b[4:0];
            5'd16: begin p = sa * sb; pb = p; r = pb[31:0]; end
            5'd17: begin p = sa * sb; pb = p; r = pb[63:32]; end
            5'd18: begin p = sa * ub; pb = p; r = pb[63:32]; end
            5'd19: begin p = ua * ub; pb = p; r = pb[63:32]; end
            5'd20: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin p = sa / sb; pb = p; r = pb[31:0]; end
            end
            5'd21: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd22: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else begin p = sa % sb; pb = p; r = pb[31:0]; end
            end
            5'd23: r = (b == 0) ? a : a % b;
            default: il = 1'b1;
        endcase
        return {il, c, v, r};
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[4:3] != 2'b10) return 1;
        if (op[2] && b == 0) return 1;
        if ((op == 5'd20 || op == 5'd22) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return XLEN + 2;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [W-1:0] exp_q[$];
    logic         m_valid = 1'b0;
    int           m_rem   = 0;

    always @(negedge clk) begin
        logic         exp_ready;
        logic [W-1:0] e;
        int           lat;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_rem   = 0;
            exp_q.delete();
        end else begin
            exp_ready = !bus.flush && ((!m_valid && m_rem == 0) || (m_valid && bus.out_ready));
            chk("in_ready", bus.in_ready, exp_ready);
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("res", bus.res, e[31:0]);
                    chk("zero", bus.zero, (e[31:0] == 0));
                    chk("neg", bus.neg, e[31]);
                    chk("ovf", bus.ovf, e[32]);
                    chk("carry", bus.carry, e[33]);
                    chk("illegal", bus.illegal, e[34]);
                end
            end
            // advance the model across the coming edge
            if (bus.flush) begin
                m_valid = 1'b0;
                m_rem   = 0;
                exp_q.delete();
            end else begin
                if (m_valid && bus.out_ready) begin
                    m_valid = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (bus.in_valid && exp_ready) begin
                    exp_q.push_back(ref_op(bus.op, bus.a, bus.b));
                    lat = ref_lat(bus.op, bus.a, bus.b);
                    if (lat == 1) m_valid = 1'b1;
                    else m_rem = lat - 1;
                end else if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) m_valid = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        n = 0;
        send(op, a, b);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_res"}, bus.res, exp_res);
        last_flags = {bus.zero, bus.neg, bus.carry, bus.ovf, bus.illegal};
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int g;
        int sel;
        logic never;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_flags", {bus.zero, bus.neg, bus.carry, bus.ovf, bus.illegal}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // pin the model with hand-computed values
        chk("model_add", ref_op(5'd0, 32'h7FFFFFFF, 32'h1), {1'b0, 1'b0, 1'b1, 32'h80000000});
        chk("model_mulhsu", ref_op(5'd18, 32'hFFFFFFFF, 32'h2), {3'b000, 32'hFFFFFFFF});
        chk("model_rem", ref_op(5'd22, 32'hFFFFFFF9, 32'h2), {3'b000, 32'hFFFFFFFF});
        chk("model_sra", ref_op(5'd11, 32'h80000000, 32'h21), {3'b000, 32'hC0000000});

        // directed
        run_dir("add_ovf", 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1);
        chk("add_ovf_flags", last_flags, 5'b01010);
        run_dir("sub_eq", 5'd1, 32'd5, 32'd5, 32'h0, 1);
        chk("sub_eq_flags", last_flags, 5'b10100);
        run_dir("sra", 5'd11, 32'h80000000, 32'h21, 32'hC0000000, 1);
        run_dir("sll", 5'd10, 32'h1, 32'd31, 32'h80000000, 1);
        run_dir("mulh", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 34);
        run_dir("mulhu", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_dir("div", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run_dir("rem", 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run_dir("divu_z", 5'd21, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
        run_dir("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
        run_dir("illegal", 5'd13, 32'h1234, 32'h5678, 32'h0, 1);
        chk("illegal_flags", last_flags, 5'b10001);

        // result held while the consumer stalls, then back-to-back accept
        bus.out_ready = 1'b0;
        send(5'd16, 32'd3, 32'd4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        chk("hold_lat", n, 34);
        repeat (5) begin
            @(negedge clk);
            chk("hold_res", bus.res, 32'd12);
            chk("hold_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(5'd0, 32'd1, 32'd1);
        @(negedge clk);
        chk("b2b_valid", bus.out_valid, 1);
        chk("b2b_res", bus.res, 32'd2);
        @(posedge clk);
        #1;

        // flush mid-divide
        send(5'd21, 32'd100, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 1);
        never = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) never = 1'b0;
        end
        chk("flush_no_result", never, 1);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a multiply
        send(5'd16, 32'h1234567, 32'h89ABCDE);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_res", bus.res, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 150; i++) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'b1;
            sel = $urandom_range(0, 9);
            ra  = rnd_word();
            rb  = rnd_word();
            if (sel <= 5) begin
                rop = 5'($urandom_range(0, 12));
            end else if (sel <= 7) begin
                rop = 5'($urandom_range(16, 23));
            end else if (sel == 8) begin
                g   = $urandom_range(0, 10);
                rop = (g < 3) ? 5'(13 + g) : 5'(21 + g);
            end else begin
                rop = 5'($urandom_range(20, 23));
                if ($urandom_range(0, 1) == 0) begin
                    rb = 32'h0;
                end else begin
                    ra = 32'h80000000;
                    rb = 32'hFFFFFFFF;
                end
            end
            send(rop, ra, rb);
        end
        bus.out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
